// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - dual-port 16-bit RAM with byte/halfword data port, fetch port and MMIO decoder
// Optional MMIO wait-timeout enabled by defining MEMORY_MMIO_TIMEOUT_EN.
module memory_unit #(
    parameter int ADDR_W       = 16,
    parameter int RAM_BYTES    = 32768,
    parameter int MMIO_BASE    = 'hFF00,
    parameter int MMIO_CH      = 2,
    parameter int MMIO_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  data_addr,
    input  logic [15:0]        data_wdata,
    input  logic               data_size,
    input  logic               data_write,
    input  logic               data_req,
    output logic [15:0]        data_rdata,
    output logic               data_done,
    output logic               data_err,
    input  logic [ADDR_W-1:0]  inst_addr,
    input  logic               inst_req,
    output logic [15:0]        inst_out,
    output logic               inst_done,
    output logic [MMIO_CH-1:0] mmio_req,
    input  logic [MMIO_CH-1:0] mmio_done
);

    localparam int RAM_WORDS = RAM_BYTES / 2;
    localparam int IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW,
        S_WR,
        S_MMIO,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [15:0] mem [RAM_WORDS];
    logic [15:0] a_rdata;
    logic [15:0] b_rdata;
    logic [15:0] a_wdata;
    logic [15:0] wr_word;
    logic [15:0] byte_merge;
    logic [15:0] rd_val;
    logic        a_we;

    logic [IDX_W-1:0]  a_idx;
    logic [IDX_W-1:0]  b_idx;
    logic              in_ram;
    logic              in_mmio;
    logic              misalign;
    logic [ADDR_W-1:0] mmio_off;
    logic [MMIO_CH-1:0] mmio_sel;
    logic              mmio_hit;
    logic              timeout_hit;
    logic              inst_in_ram;
    logic              inst_hit;

    logic              done_d;
    logic              err_d;
    logic [15:0]       rdata_d;
    logic [MMIO_CH-1:0] req_d;

    // Address decode; the requester holds data_addr for the whole transaction.
    assign a_idx    = data_addr[IDX_W:1];
    assign b_idx    = inst_addr[IDX_W:1];
    assign in_ram   = {1'b0, data_addr} < (ADDR_W+1)'(RAM_BYTES);
    assign mmio_off = data_addr - ADDR_W'(MMIO_BASE);
    assign in_mmio  = (data_addr >= ADDR_W'(MMIO_BASE)) && (mmio_off < ADDR_W'(MMIO_CH));
    assign mmio_sel = MMIO_CH'(1) << mmio_off;
    assign misalign = data_size & data_addr[0];
    assign mmio_hit = |(mmio_done & mmio_req);

    assign inst_in_ram = {1'b0, inst_addr} < (ADDR_W+1)'(RAM_BYTES);

    // Port A: read-first, read every cycle so RD/RMW see the word fetched at the request edge.
    assign a_we = (state == S_WR);
    always_ff @(posedge clock) begin
        if (a_we) begin
            mem[a_idx] <= a_wdata;
        end
        a_rdata <= mem[a_idx];
    end

    // Port B: read-only fetch port, old data on a same-edge port A write.
    always_ff @(posedge clock) begin
        b_rdata <= mem[b_idx];
    end

    assign byte_merge = data_addr[0] ? {data_wdata[7:0], a_rdata[7:0]}
                                     : {a_rdata[15:8], data_wdata[7:0]};

    always_ff @(posedge clock) begin
        if (state == S_RMW) begin
            wr_word <= byte_merge;
        end
    end

    assign a_wdata = data_size ? data_wdata : wr_word;
    assign rd_val  = data_size ? a_rdata
                               : {8'h00, (data_addr[0] ? a_rdata[15:8] : a_rdata[7:0])};

`ifdef MEMORY_MMIO_TIMEOUT_EN
    localparam int CNT_W = ($clog2(MMIO_TIMEOUT + 1) > 8) ? $clog2(MMIO_TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == S_MMIO) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign timeout_hit = (state == S_MMIO) && !mmio_hit && (tmo_cnt == CNT_W'(MMIO_TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (MMIO_TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            data_done  <= 1'b0;
            data_err   <= 1'b0;
            data_rdata <= '0;
            mmio_req   <= '0;
        end else begin
            state      <= next_state;
            data_done  <= done_d;
            data_err   <= err_d;
            data_rdata <= rdata_d;
            mmio_req   <= req_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (data_req) begin
                    if (misalign) begin
                        next_state = S_DONE;
                    end else if (in_ram) begin
                        if (!data_write) begin
                            next_state = S_RD;
                        end else if (data_size) begin
                            next_state = S_WR;
                        end else begin
                            next_state = S_RMW;
                        end
                    end else if (in_mmio) begin
                        next_state = S_MMIO;
                    end else begin
                        next_state = S_DONE;
                    end
                end
            end
            S_RD:    next_state = S_DONE;
            S_RMW:   next_state = S_WR;
            S_WR:    next_state = S_DONE;
            S_MMIO: begin
                if (mmio_hit || timeout_hit) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; IDLE straight to DONE is always an error.
    always_comb begin
        done_d  = (next_state == S_DONE);
        err_d   = ((state == S_IDLE) && (next_state == S_DONE)) || timeout_hit;
        rdata_d = (state == S_RD) ? rd_val : 16'h0000;
        req_d   = '0;
        if ((state == S_IDLE) && (next_state == S_MMIO)) begin
            req_d = mmio_sel;
        end else if ((state == S_MMIO) && (next_state == S_MMIO)) begin
            req_d = mmio_req;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inst_done <= 1'b0;
            inst_hit  <= 1'b0;
        end else begin
            inst_done <= inst_req;
            inst_hit  <= inst_req & inst_in_ram;
        end
    end

    assign inst_out = (inst_done && inst_hit) ? b_rdata : 16'h0000;

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - scoreboard bench for memory_unit against a byte-array reference model
// Exercises MEMORY_MMIO_TIMEOUT_EN behaviour when that macro is defined.
module tb_memory_unit;

    localparam int RAM_BYTES    = 32768;
    localparam int MMIO_BASE    = 'hFF00;
    localparam int MMIO_CH      = 2;
    localparam int MMIO_TIMEOUT = 255;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [15:0]        data_addr = '0;
    logic [15:0]        data_wdata = '0;
    logic               data_size = 1'b0;
    logic               data_write = 1'b0;
    logic               data_req = 1'b0;
    logic [15:0]        data_rdata;
    logic               data_done;
    logic               data_err;
    logic [15:0]        inst_addr = '0;
    logic               inst_req = 1'b0;
    logic [15:0]        inst_out;
    logic               inst_done;
    logic [MMIO_CH-1:0] mmio_req;
    logic [MMIO_CH-1:0] mmio_done = '0;

    memory_unit #(
        .ADDR_W(16), .RAM_BYTES(RAM_BYTES), .MMIO_BASE(MMIO_BASE),
        .MMIO_CH(MMIO_CH), .MMIO_TIMEOUT(MMIO_TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_size(data_size),
        .data_write(data_write), .data_req(data_req), .data_rdata(data_rdata),
        .data_done(data_done), .data_err(data_err),
        .inst_addr(inst_addr), .inst_req(inst_req), .inst_out(inst_out), .inst_done(inst_done),
        .mmio_req(mmio_req), .mmio_done(mmio_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model [0:65535];

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } dexp_t;

    dexp_t       dexp_q [$];
    logic [15:0] iexp_q [$];
    int          inst_mode = 0;
    logic [15:0] inst_fix = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_word(input int a);
        return {model[a | 1], model[a & ~1]};
    endfunction

    // Fetch stimulus: expectation taken from the model as it stands before the fetch edge.
    always @(negedge clock) begin
        if (inst_mode == 0) begin
            inst_req = 1'b0;
        end else begin
            int a;
            if (inst_mode == 2) begin
                a = inst_fix;
                inst_req = 1'b1;
            end else begin
                a = ($urandom % 8 == 0) ? RAM_BYTES + int'($urandom % 1000) : int'($urandom % 64);
                inst_req = ($urandom % 4) != 0;
            end
            inst_addr = a[15:0];
            if (inst_req) begin
                iexp_q.push_back((a < RAM_BYTES) ? model_word(a) : 16'h0000);
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents a completion.
    always @(negedge clock) begin
        if (reset) begin
            if (data_done) begin
                if (dexp_q.size() == 0) begin
                    check("data_unexpected_done", data_done, 1'b0);
                end else begin
                    dexp_t e;
                    e = dexp_q.pop_front();
                    check("data_rdata", data_rdata, e.rdata);
                    check("data_err", data_err, e.err);
                end
            end else if (data_err) begin
                check("err_without_done", data_err, 1'b0);
            end
            if (inst_done) begin
                if (iexp_q.size() == 0) begin
                    check("inst_unexpected_done", inst_done, 1'b0);
                end else begin
                    check("inst_out", inst_out, iexp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after one idle cycle.
    task automatic do_txn(input logic [15:0] addr, input logic size, input logic write,
                          input logic [15:0] wdata, input int delay);
        int                 a;
        int                 lat;
        int                 ch;
        int                 n;
        logic               err;
        logic [15:0]        rd;
        logic               commit;
        logic [MMIO_CH-1:0] oh;
        a = addr;
        ch = -1;
        err = 1'b0;
        rd = 16'h0000;
        commit = 1'b0;
        oh = '0;
        if (size && addr[0]) begin
            err = 1'b1;
            lat = 1;
        end else if (a < RAM_BYTES) begin
            if (!write) begin
                lat = 2;
                rd = size ? model_word(a) : {8'h00, model[a]};
            end else begin
                lat = size ? 2 : 3;
                commit = 1'b1;
            end
        end else if (a >= MMIO_BASE && a < MMIO_BASE + MMIO_CH) begin
            ch = a - MMIO_BASE;
            oh = MMIO_CH'(1) << ch;
            if (delay > 0) begin
                lat = delay + 1;
            end else begin
                lat = MMIO_TIMEOUT + 1;
                err = 1'b1;
            end
        end else begin
            err = 1'b1;
            lat = 1;
        end
        dexp_q.push_back('{rdata: rd, err: err});

        data_addr  = addr;
        data_size  = size;
        data_write = write;
        data_wdata = wdata;
        data_req   = 1'b1;
        for (n = 1; n <= 600; n++) begin
            @(posedge clock);
            #1;
            mmio_done = '0;
            if (data_done) break;
            if (ch >= 0) begin
                if (n <= 8) check("mmio_req_held", mmio_req, oh);
                if (delay > 0 && n == delay) mmio_done = oh;
            end
        end
        if (n > 600) begin
            check("data_done_timeout", 32'(n), 32'(lat));
        end else begin
            check("latency", 32'(n), 32'(lat));
            if (ch >= 0) check("mmio_req_drop", mmio_req, '0);
        end
        if (commit) begin
            model[a] = wdata[7:0];
            if (size) model[a + 1] = wdata[15:8];
        end
        data_req = 1'b0;
        @(posedge clock);
        #1;
        check("done_pulse", data_done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_data_rdata", data_rdata, 16'h0);
        check("rst_data_done", data_done, 1'b0);
        check("rst_data_err", data_err, 1'b0);
        check("rst_inst_out", inst_out, 16'h0);
        check("rst_inst_done", inst_done, 1'b0);
        check("rst_mmio_req", mmio_req, '0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int a = 0; a < 64; a += 2) do_txn(16'(a), 1'b1, 1'b1, 16'($urandom), 0);

        do_txn(16'h0010, 1'b1, 1'b1, 16'hBEEF, 0);
        do_txn(16'h0010, 1'b1, 1'b0, 16'h0000, 0);
        do_txn(16'h0011, 1'b0, 1'b0, 16'h0000, 0);
        do_txn(16'h0010, 1'b1, 1'b1, 16'h1234, 0);
        inst_fix  = 16'h0010;
        inst_mode = 2;
        do_txn(16'h0011, 1'b0, 1'b1, 16'h005A, 0);
        inst_mode = 0;
        do_txn(16'h0010, 1'b1, 1'b0, 16'h0000, 0);
        check("rmw_word", model_word(16'h0010), 16'h5A34);

        do_txn(16'h0003, 1'b1, 1'b0, 16'h0000, 0);
        do_txn(16'h0003, 1'b1, 1'b1, 16'hDEAD, 0);
        do_txn(16'h0002, 1'b1, 1'b0, 16'h0000, 0);
        do_txn(16'h1000, 1'b1, 1'b1, 16'hC0DE, 0);
        do_txn(16'h9000, 1'b1, 1'b1, 16'hFFFF, 0);
        do_txn(16'h9000, 1'b0, 1'b0, 16'h0000, 0);
        do_txn(16'h1000, 1'b1, 1'b0, 16'h0000, 0);
        do_txn(16'hFF01, 1'b0, 1'b1, 16'h0041, 4);
        do_txn(16'hFF00, 1'b1, 1'b0, 16'h0000, 1);
        do_txn(16'hFF02, 1'b0, 1'b0, 16'h0000, 0);

        inst_mode = 1;
        for (int i = 0; i < 150; i++) begin
            int          r;
            logic [15:0] ad;
            r = $urandom % 10;
            if (r < 7) ad = 16'($urandom % 64);
            else if (r == 7) ad = 16'(RAM_BYTES + $urandom % (MMIO_BASE - RAM_BYTES));
            else if (r == 8) ad = 16'(MMIO_BASE + $urandom % MMIO_CH);
            else ad = 16'(MMIO_BASE + MMIO_CH + $urandom % (256 - MMIO_CH));
            do_txn(ad, 1'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(1, 5)));
        end
        inst_mode = 0;

`ifdef MEMORY_MMIO_TIMEOUT_EN
        do_txn(16'hFF00, 1'b0, 1'b1, 16'h0000, 0);
`endif

        do_txn(16'h0020, 1'b1, 1'b1, 16'h1234, 0);
        inst_fix  = 16'h0020;
        inst_mode = 2;
        @(posedge clock);
        #1;
        data_addr  = 16'h0021;
        data_size  = 1'b0;
        data_write = 1'b1;
        data_wdata = 16'h005A;
        data_req   = 1'b1;
        @(posedge clock);
        #1;
        check("pre_reset_inst_done", inst_done, 1'b1);
        #1;
        reset     = 1'b0;
        inst_mode = 0;
        #1;
        check("arst_data_done", data_done, 1'b0);
        check("arst_inst_done", inst_done, 1'b0);
        check("arst_inst_out", inst_out, 16'h0);
        check("arst_mmio_req", mmio_req, '0);
        data_req = 1'b0;
        iexp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_txn(16'h0020, 1'b1, 1'b0, 16'h0000, 0);

        repeat (4) @(posedge clock);
        #1;
        check("data_sb_empty", 32'(dexp_q.size()), 32'd0);
        check("inst_sb_empty", 32'(iexp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
